// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct codes,
// ALU operation codes and controller states.
package mips_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StRExec,
        StRWb,
        StIExec,
        StIWb,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StBranch,
        StJump,
        StTrap
    } state_e;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; flags funct codes the controller does not support.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = AluAdd;
        illegal  = 1'b0;
        case (funct)
            FnAdd:   alu_ctrl = AluAdd;
            FnSub:   alu_ctrl = AluSub;
            FnAnd:   alu_ctrl = AluAnd;
            FnOr:    alu_ctrl = AluOr;
            FnSlt:   alu_ctrl = AluSlt;
            default: illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with bounded memory wait, sticky trap state and
// a retired-instruction counter.
module mc_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  inst_31_26,
    input  logic [5:0]  inst_5_0,
    input  logic        mem_ready,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        jump,
    output logic [3:0]  ALU_Control,
    output logic        pc_write,
    output logic        ir_write,
    output logic        trap,
    output logic [15:0] instr_count
);

    localparam int unsigned WaitW = $clog2(MEM_WAIT_MAX + 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q;
    logic [15:0]      count_q;
    logic [3:0]       r_alu;
    logic             r_illegal;
    logic             wait_expired;

    alu_decoder u_alu_decoder (
        .funct    (inst_5_0),
        .alu_ctrl (r_alu),
        .illegal  (r_illegal)
    );

    // True when one more un-ready cycle would reach the wait limit.
    assign wait_expired = (wait_q == WaitW'(MEM_WAIT_MAX - 1));
    assign instr_count  = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StMemAddr) begin
                wait_q <= '0;
            end else if ((state_q == StMemRd || state_q == StMemWr) && !mem_ready) begin
                wait_q <= wait_q + WaitW'(1);
            end
            if (pc_write) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        ALU_Control = AluAdd;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        trap        = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write = 1'b1;
                state_d  = StDecode;
            end
            StDecode: begin
                case (inst_31_26)
                    OpRtype:     state_d = r_illegal ? StTrap : StRExec;
                    OpAddi:      state_d = StIExec;
                    OpLw, OpSw:  state_d = StMemAddr;
                    OpBeq:       state_d = StBranch;
                    OpJ:         state_d = StJump;
                    default:     state_d = StTrap;
                endcase
            end
            StRExec: begin
                ALU_Control = r_alu;
                state_d     = StRWb;
            end
            StRWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StIExec: begin
                alu_src = 1'b1;
                state_d = StIWb;
            end
            StIWb: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StMemAddr: begin
                alu_src = 1'b1;
                state_d = (inst_31_26 == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end
            end
            StMemWb: begin
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                pc_write   = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                if (mem_ready) begin
                    pc_write = 1'b1;
                    state_d  = StFetch;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end
            end
            StBranch: begin
                branch      = 1'b1;
                ALU_Control = AluSub;
                pc_write    = 1'b1;
                state_d     = StFetch;
            end
            StJump: begin
                jump     = 1'b1;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StTrap: begin
                trap = 1'b1;
            end
            default: state_d = StTrap;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction stream against an instruction-level model of expected
// latency and control-signal activity, plus directed trap and reset scenarios.
module tb_mc_control;

    localparam int unsigned WaitMax = 15;

    localparam int KR = 0, KAddi = 1, KLw = 2, KSw = 3, KBeq = 4, KJ = 5;

    typedef struct {
        int         cycles;
        int         reg_write;
        int         reg_dst;
        int         alu_src;
        int         mem_read;
        int         mem_write;
        int         mem_to_reg;
        int         branch;
        int         jump;
        int         alu_other;
        logic [3:0] alu_exec;
    } summary_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  inst_31_26 = 6'd0;
    logic [5:0]  inst_5_0 = 6'd0;
    logic        mem_ready = 1'b0;
    logic        reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump;
    logic [3:0]  ALU_Control;
    logic        pc_write, ir_write, trap;
    logic [15:0] instr_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_count = 16'd0;

    always #5 clk = ~clk;

    mc_control #(.MEM_WAIT_MAX(WaitMax)) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_31_26  (inst_31_26),
        .inst_5_0    (inst_5_0),
        .mem_ready   (mem_ready),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src     (alu_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .branch      (branch),
        .jump        (jump),
        .ALU_Control (ALU_Control),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .trap        (trap),
        .instr_count (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] opcode_of(input int kind);
        case (kind)
            KR:      return 6'b000000;
            KAddi:   return 6'b001000;
            KLw:     return 6'b100011;
            KSw:     return 6'b101011;
            KBeq:    return 6'b000100;
            default: return 6'b000010;
        endcase
    endfunction

    function automatic logic [3:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [5:0] random_funct();
        logic [5:0] tbl [5];
        tbl[0] = 6'b100000; tbl[1] = 6'b100010; tbl[2] = 6'b100100;
        tbl[3] = 6'b100101; tbl[4] = 6'b101010;
        return tbl[$urandom_range(0, 4)];
    endfunction

    // Expected per-instruction activity, counted in cycles, from the instruction rules.
    function automatic summary_t expect_of(input int kind, input logic [5:0] f, input int w);
        summary_t e;
        e = '{default: 0, alu_exec: 4'b0010};
        case (kind)
            KR: begin
                e.cycles = 4; e.reg_write = 1; e.reg_dst = 1;
                e.alu_exec = alu_of_funct(f);
                e.alu_other = (e.alu_exec != 4'b0010) ? 1 : 0;
            end
            KAddi: begin
                e.cycles = 4; e.reg_write = 1; e.alu_src = 2;
            end
            KLw: begin
                e.cycles = 5 + w; e.reg_write = 1; e.mem_to_reg = 1;
                e.mem_read = w + 2; e.alu_src = w + 3;
            end
            KSw: begin
                e.cycles = 4 + w; e.mem_write = w + 1; e.alu_src = w + 2;
            end
            KBeq: begin
                e.cycles = 3; e.branch = 1; e.alu_exec = 4'b0110; e.alu_other = 1;
            end
            default: begin
                e.cycles = 3; e.jump = 1;
            end
        endcase
        return e;
    endfunction

    // Release lands just after a rising edge so the next falling edge sees FETCH.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ir_write", ir_write, 1);
        check("rst_trap", trap, 0);
        check("rst_count", instr_count, 0);
        check("rst_ctrl", {reg_write, mem_write, pc_write, mem_read}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_count = 16'd0;
    endtask

    task automatic run_instr(input int kind, input logic [5:0] f, input int w);
        summary_t e, o;
        int       cyc;
        bit       done;
        bit       is_mem;
        e = expect_of(kind, f, w);
        o = '{default: 0, alu_exec: 4'b0010};
        is_mem = (kind == KLw) || (kind == KSw);
        inst_31_26 = opcode_of(kind);
        inst_5_0 = (kind == KR) ? f : 6'($urandom);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (is_mem && cyc >= 3) mem_ready = (cyc >= 3 + w);
            else mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) begin
                check("count", instr_count, model_count);
                check("ir_write_fetch", ir_write, 1);
            end else if (ir_write) begin
                check("ir_write_late", ir_write, 0);
            end
            if (trap) check("trap_unexpected", trap, 0);
            o.reg_write += reg_write;
            o.reg_dst += reg_dst;
            o.alu_src += alu_src;
            o.mem_read += mem_read;
            o.mem_write += mem_write;
            o.mem_to_reg += mem_to_reg;
            o.branch += branch;
            o.jump += jump;
            if (ALU_Control != 4'b0010) o.alu_other++;
            if (cyc == 2) o.alu_exec = ALU_Control;
            if (pc_write) done = 1'b1;
            cyc++;
        end
        check("retired", done, 1);
        check("cycles", cyc, e.cycles);
        check("reg_write", o.reg_write, e.reg_write);
        check("reg_dst", o.reg_dst, e.reg_dst);
        check("alu_src", o.alu_src, e.alu_src);
        check("mem_read", o.mem_read, e.mem_read);
        check("mem_write", o.mem_write, e.mem_write);
        check("mem_to_reg", o.mem_to_reg, e.mem_to_reg);
        check("branch", o.branch, e.branch);
        check("jump", o.jump, e.jump);
        check("alu_exec", o.alu_exec, e.alu_exec);
        check("alu_other", o.alu_other, e.alu_other);
        if (done) model_count = model_count + 16'd1;
        else do_reset();
    endtask

    // Runs a fixed window expecting the FSM to lock in TRAP at cycle first_trap.
    task automatic run_trap(input string tag, input logic [5:0] op, input logic [5:0] f,
                            input int first_trap, input int exp_mem_write);
        int n_pc, n_rw, n_mw, n_trap, first;
        n_pc = 0; n_rw = 0; n_mw = 0; n_trap = 0; first = -1;
        inst_31_26 = op;
        inst_5_0 = f;
        for (int cyc = 0; cyc < first_trap + 7; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (cyc == 0) check({tag, "_count"}, instr_count, model_count);
            n_pc += pc_write;
            n_rw += reg_write;
            n_mw += mem_write;
            n_trap += trap;
            if (trap && first < 0) first = cyc;
        end
        check({tag, "_pc_write"}, n_pc, 0);
        check({tag, "_reg_write"}, n_rw, 0);
        check({tag, "_mem_write"}, n_mw, exp_mem_write);
        check({tag, "_first_trap"}, first, first_trap);
        check({tag, "_trap_cycles"}, n_trap, 7);
        check({tag, "_count_hold"}, instr_count, model_count);
        do_reset();
    endtask

    initial begin
        int kind, w;
        logic [5:0] f;
        do_reset();

        run_instr(KR, 6'b100000, 0);
        run_instr(KLw, 6'd0, 3);
        run_instr(KSw, 6'd0, 0);
        run_instr(KSw, 6'd0, WaitMax - 1);
        run_instr(KLw, 6'd0, WaitMax - 1);
        run_instr(KBeq, 6'd0, 0);
        run_instr(KJ, 6'd0, 0);
        run_instr(KAddi, 6'd0, 0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            f = random_funct();
            w = ($urandom_range(0, 9) == 0) ? WaitMax - 1 : $urandom_range(0, 6);
            run_instr(kind, f, w);
        end

        run_trap("bad_op", 6'b111111, 6'b100000, 2, 0);
        run_trap("bad_funct", 6'b000000, 6'b111111, 2, 0);
        run_instr(KJ, 6'd0, 0);
        run_trap("sw_timeout", 6'b101011, 6'd0, 3 + WaitMax, WaitMax);

        // Reset in the middle of a store wait.
        run_instr(KR, 6'b100010, 0);
        run_instr(KJ, 6'd0, 0);
        inst_31_26 = 6'b101011;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            mem_ready = 1'b0;
        end
        #1 check("pre_rst_mem_write", mem_write, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mem_write", mem_write, 0);
        check("mid_rst_pc_write", pc_write, 0);
        check("mid_rst_reg_write", reg_write, 0);
        check("mid_rst_ir_write", ir_write, 1);
        check("mid_rst_alu_src", alu_src, 0);
        check("mid_rst_alu", ALU_Control, 4'b0010);
        check("mid_rst_count", instr_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_count = 16'd0;
        run_instr(KJ, 6'd0, 0);
        run_instr(KAddi, 6'd0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
